// File: rtl/led_frame_scheduler.sv
// Double-buffered 16x16 monochrome frame store: nibble-stream writer fills the back bank, the
// scan side reads rows from the front bank. Optional reset test pattern: LED_FRAME_TEST_PATTERN_EN.
module led_frame_scheduler #(
  parameter int unsigned HOLD_FRAMES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  input  logic [3:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        frame_end,
  output logic        swap_pending,
  output logic        front_sel,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [0:0] {StFill, StWait} state_e;

  state_e      state_q, state_d;
  logic [5:0]  wp_q, wp_d;
  logic [3:0]  hc_q, hc_d;
  logic        front_sel_q, front_sel_d;
  logic        err_q, err_d;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic [15:0] bank_q [2][16];

  logic        wr_en;
  logic        new_err;
  logic        swap;
  logic        back_sel;

  assign back_sel = ~front_sel_q;
  // Swap needs WAIT before this edge, so completing nibble 63 with frame_end never swaps.
  assign swap = frame_end && (state_q == StWait) &&
                (({1'b0, hc_q} + 5'd1) >= 5'(HOLD_FRAMES));

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    hc_d        = hc_q;
    front_sel_d = front_sel_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    new_err     = 1'b0;
    case (state_q)
      StFill: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wp_q == 6'd63) begin
            state_d = StWait;
            wp_d    = '0;
            new_err = ~wr_last;
          end else if (wr_last) begin
            new_err = 1'b1;
            wp_d    = '0;
          end else begin
            wp_d = wp_q + 6'd1;
          end
        end
      end
      StWait: begin
        if (swap) begin
          state_d     = StFill;
          front_sel_d = ~front_sel_q;
        end
      end
      default: state_d = StFill;
    endcase
    if (swap) begin
      hc_d = '0;
    end else if (frame_end && (hc_q != 4'hF)) begin
      hc_d = hc_q + 4'd1;
    end
    // A new error beats a same-cycle clear.
    if (err_clr) err_d = 1'b0;
    if (new_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFill;
      wp_q        <= '0;
      hc_q        <= '0;
      front_sel_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      hc_q        <= hc_d;
      front_sel_q <= front_sel_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 16; r++) begin
          bank_q[b][r] <= '0;
        end
      end
`ifdef LED_FRAME_TEST_PATTERN_EN
      for (int r = 0; r < 16; r++) begin
        bank_q[0][r] <= (16'd1 << r) | (16'd1 << (15 - r));
      end
`endif
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_q <= bank_q[front_sel_q][rd_addr];
      end
      if (wr_en) begin
        bank_q[back_sel][wp_q[5:2]][{wp_q[1:0], 2'b00} +: 4] <= wr_data;
      end
    end
  end

  assign wr_ready     = (state_q == StFill);
  assign swap_pending = (state_q == StWait);
  assign front_sel    = front_sel_q;
  assign err          = err_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Double-buffered 16x16 monochrome frame store that sits between the host input pins and the LED panel scan driver. A 4-bit host write stream fills the back buffer while the scan driver reads rows from the front buffer. The two buffers swap only at a scan frame boundary, so the panel never shows a partially written frame. The block owns both buffers and arbitrates ownership between writer and reader.

## Interface
- HOLD_FRAMES, default 1: minimum number of `frame_end` pulses per displayed frame; legal range 1..15.
- clk  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  host nibble valid.
- wr_data  in  4  host nibble.
- wr_last  in  1  marks final nibble of a frame.
- wr_ready  out  1  back buffer accepts a nibble this cycle.
- rd_req  in  1  scan-side row read request.
- rd_addr  in  4  row index.
- rd_data  out  16  front-buffer row, registered.
- rd_valid  out  1  `rd_data` valid; one-cycle pulse.
- frame_end  in  1  single-cycle pulse from the scan driver at the end of a full panel scan.
- swap_pending  out  1  back buffer complete, waiting for a swap.
- front_sel  out  1  index of the buffer currently displayed.
- err  out  1  sticky framing error.
- err_clr  in  1  synchronous clear of `err`.

## Operation
- Storage: two banks, `buf[b][row][15:0]`. The front bank is `front_sel`; the back bank is `~front_sel`.
- Write pointer `wp` is 6 bits and counts nibbles 0..63:
  - row = `wp[5:2]`.
  - Nibble `wp[1:0]` maps to bits `[4*wp[1:0]+3 : 4*wp[1:0]]`.
- Write states:
  - FILL: `wr_ready`=1. Each transfer (`wr_valid & wr_ready`) writes the addressed nibble of the back bank, then `wp++`.
  - Transfer with `wp`==63: the frame is complete. Go to WAIT, `swap_pending`=1, `wp`=0. If `wr_last`=0 on this transfer, `err`=1, but the frame is still committed.
  - Transfer with `wr_last`=1 and `wp`!=63: framing error. `err`=1, `wp`=0, the frame is discarded, stay in FILL, no swap. Partial back-bank contents are don't-care.
  - WAIT: `wr_ready`=0. `wr_valid` is ignored and does not set `err`.
- Hold counter `hc` is 4 bits and saturates at 15:
  - Increments on every `frame_end` that does not cause a swap.
  - Cleared to 0 on a swap.
- Swap condition: `frame_end` & WAIT & (`hc`+1 >= HOLD_FRAMES).
  - On swap: `front_sel` toggles, `swap_pending`=0, go to FILL.
  - `frame_end` in FILL: no swap; `hc` still counts.
- Read:
  - `rd_req`=1 registers `buf[front_sel][rd_addr]` into `rd_data`, and `rd_valid`=1 on the next cycle.
  - `rd_req`=0: `rd_valid`=0 and `rd_data` holds its value.
  - Reads are never stalled. Front and back banks never conflict.
- Simultaneous events:
  - `rd_req` and a swap on the same edge: the read uses the pre-swap `front_sel`.
  - The write completing nibble 63 and `frame_end` on the same edge: no swap. The swap needs WAIT to already be the state before that edge, so it occurs at the next qualifying `frame_end`.
  - `err_clr` and a new error on the same edge: the error wins, `err`=1.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - `wr_ready`=1, `rd_data`=0, `rd_valid`=0, `swap_pending`=0, `front_sel`=0, `err`=0.
  - `wp`=0, `hc`=0, state FILL.
  - Both banks cleared, except as noted under Configuration.
- Read latency: 1 cycle, request to `rd_valid`/`rd_data`. One request per cycle is sustained.
- Write throughput: 1 nibble per cycle while in FILL.
- `wr_ready` falls in the cycle after the nibble-63 transfer, and rises in the cycle after the swap.
- Reset asserted mid-frame: everything reinitialises immediately and the partial frame is lost. After release, the first edge is a normal FILL cycle.

## Configuration
- `LED_FRAME_TEST_PATTERN_EN` defined: reset loads bank 0 (the front bank) with an X pattern, `buf[0][i]` = (1<<i) | (1<<(15-i)) for i=0..15. Bank 1 clears to 0.
- Undefined: both banks clear to 0 on reset.
- Either way, the pattern is only a reset value and all other behaviour is identical.

## Test plan
- Reset, then `rd_req` with `rd_addr`=5 -> next cycle `rd_valid`=1. `rd_data`=0x0000; with `LED_FRAME_TEST_PATTERN_EN`, 0x0420.
- Write 64 nibbles of 0xA with `wr_last` on nibble 63 -> `swap_pending`=1, `wr_ready`=0. A `frame_end` pulse then gives `front_sel`=1, and a read of any row returns 0xAAAA.
- HOLD_FRAMES=3, complete frame, three `frame_end` pulses -> swap only on the third; `swap_pending` stays 1 through the first two.
- `wr_last` on nibble 10 -> `err`=1, `wp` returns to 0, no swap. `err_clr` gives `err`=0 on the next cycle. A following 64-nibble frame swaps normally.
- `rd_req` with `rd_addr`=0 asserted on the same edge as a swap -> `rd_data` comes from the old front bank; the next read returns the new bank.
- Assert `reset_n`=0 after 30 nibbles -> `front_sel`=0, `wr_ready`=1, `err`=0 immediately. The next full frame swaps correctly.
